key_sw_io: RTL

- Memory-mapped input device for the board KEY pushbuttons and SW switches.
- Sits between the raw board pins and the processor's data-memory/I-O decode.
- Synchronizes and debounces both input banks, then exposes data and status registers on the data-memory bus.
- Gives software sticky Ready/Overrun edge-capture semantics, so the processor polls a status bit instead of sampling bouncing pins.

---
 rtl/key_sw_io.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/key_sw_io.sv
// Memory-mapped KEY/SW input device: 2-flop sync, per-bank debounce, sticky Ready/Overrun status.
// Latency: pin to debounced data is 2+DEBOUNCE_CYCLES clocks; rdData/hit are combinational from addr.
// Backpressure: none, every load/store completes in one cycle. Optional IRQ/IE logic under IO_IRQ_EN.

module key_sw_io_bank #(
    parameter int   W       = 4,
    parameter int   CYCLES  = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] pin,
    input  logic         rd_clr,
    input  logic         wr_ctrl,
    input  logic         wr_ovr,
    output logic [W-1:0] deb,
    output logic         rdy,
    output logic         ovr
);
    localparam int            CW       = $clog2(CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 2);

    logic [W-1:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q, rdy_d, ovr_q, ovr_d, chg;

    always_comb begin
        sync1_d = pin;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        if (sync2_q == deb_q || sync2_q != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // The increment that would reach CYCLES-1 commits the new value instead.
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        chg   = (deb_d != deb_q);
        rdy_d = chg ? 1'b1 : (rd_clr ? 1'b0 : rdy_q);
        ovr_d = ovr_q;
        if (wr_ctrl && !wr_ovr) ovr_d = 1'b0;
        if (chg && rdy_q && !rd_clr) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= {W{RST_VAL}};
            sync2_q <= {W{RST_VAL}};
            prev_q  <= {W{RST_VAL}};
            deb_q   <= {W{RST_VAL}};
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign deb = deb_q;
    assign rdy = rdy_q;
    assign ovr = ovr_q;
endmodule

module key_sw_io #(
    parameter int               DBITS           = 32,
    parameter int               NKEY            = 4,
    parameter int               NSW             = 10,
    parameter int               DEBOUNCE_CYCLES = 100000,
    parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SDATA      = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEY-1:0]  KEY,
    input  logic [NSW-1:0]   SW,
    input  logic [DBITS-1:0] addr,
    input  logic             rdEn,
    input  logic             wrEn,
    input  logic [DBITS-1:0] wrData,
    output logic [DBITS-1:0] rdData,
    output logic             hit,
    output logic             irq
);
    logic            kdata_sel, sdata_sel, kctrl_sel, sctrl_sel;
    logic [NKEY-1:0] key_deb;
    logic [NSW-1:0]  sw_deb;
    logic            krdy, kovr, srdy, sovr, kie, sie;
    logic            unused_wr;

    assign kdata_sel = (addr == ADDR_KDATA);
    assign sdata_sel = (addr == ADDR_SDATA);
    assign kctrl_sel = (addr == ADDR_KCTRL);
    assign sctrl_sel = (addr == ADDR_SCTRL);
    assign hit       = kdata_sel | sdata_sel | kctrl_sel | sctrl_sel;
    assign unused_wr = ^wrData;

    // Keys are active-low on the board, so they idle (and reset) at all ones.
    key_sw_io_bank #(.W(NKEY), .CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_key (
        .clk(clk), .reset(reset), .pin(KEY),
        .rd_clr(rdEn && kdata_sel), .wr_ctrl(wrEn && kctrl_sel), .wr_ovr(wrData[1]),
        .deb(key_deb), .rdy(krdy), .ovr(kovr)
    );

    key_sw_io_bank #(.W(NSW), .CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_sw (
        .clk(clk), .reset(reset), .pin(SW),
        .rd_clr(rdEn && sdata_sel), .wr_ctrl(wrEn && sctrl_sel), .wr_ovr(wrData[1]),
        .deb(sw_deb), .rdy(srdy), .ovr(sovr)
    );

`ifdef IO_IRQ_EN
    logic kie_q, kie_d, sie_q, sie_d, irq_q, irq_d;

    always_comb begin
        kie_d = (wrEn && kctrl_sel) ? wrData[8] : kie_q;
        sie_d = (wrEn && sctrl_sel) ? wrData[8] : sie_q;
        irq_d = (krdy & kie_q) | (srdy & sie_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kie_q <= 1'b0;
            sie_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            kie_q <= kie_d;
            sie_q <= sie_d;
            irq_q <= irq_d;
        end
    end

    assign kie = kie_q;
    assign sie = sie_q;
    assign irq = irq_q;
`else
    assign kie = 1'b0;
    assign sie = 1'b0;
    assign irq = 1'b0;
`endif

    always_comb begin
        rdData = '0;
        if (kdata_sel) rdData = {{(DBITS-NKEY){1'b0}}, ~key_deb};
        if (sdata_sel) rdData = {{(DBITS-NSW){1'b0}}, sw_deb};
        if (kctrl_sel) rdData = {{(DBITS-9){1'b0}}, kie, 6'b0, kovr, krdy};
        if (sctrl_sel) rdData = {{(DBITS-9){1'b0}}, sie, 6'b0, sovr, srdy};
    end
endmodule
